// File: rtl/ram8_bank_pkg.sv
// ram8_bank_pkg: shared types and constants for the 8-word register bank.
// Holds the FSM state type and encodings, the bank geometry, and the
// default clear value used by the clear sweep.
package ram8_bank_pkg;

  // FSM state type with legacy-compatible constant encodings
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SWEEP = 1'b1;

  // Bank geometry
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  // Default word value written by a clear sweep
  localparam logic [15:0] CLR_VAL_DEF = 16'h0000;

endpackage : ram8_bank_pkg

// File: rtl/ram8_bank_dmux8way_load.sv
// dmux8way_load: decodes the write strobe and 3-bit address into an
// 8-bit one-hot word write enable. All enables are zero when load_i is low.
module dmux8way_load
  import ram8_bank_pkg::*;
(
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DEPTH-1:0]  we_o
);

  // One-hot decode gated by the strobe
  always_comb begin
    we_o = '0;
    if (load_i) begin
      we_o[addr_i] = 1'b1;
    end
  end

endmodule : dmux8way_load

// File: rtl/ram8_bank.sv
// ram8_bank: 8 x WIDTH register bank with a registered 1-cycle read port
// and an 8-cycle clear sweep that writes CLR_VAL to every word.
//
// Handshake: out_vld is high for exactly the cycles where out holds the
// word read at the previous edge while the bank was IDLE; it is low during
// a sweep (busy=1) and in the first cycle after a sweep ends. There is no
// back-pressure: loads and reads are accepted on every IDLE edge.
//
// Configuration macro: RAM8_BANK_BYPASS_EN -- when defined, an IDLE load
// forwards its write data onto out at the same edge (write-through).
// When undefined, a same-cycle load and read return the old word.
module ram8_bank
  import ram8_bank_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] CLR_VAL = WIDTH'(CLR_VAL_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic              clr,
  output logic              busy,
  output logic [WIDTH-1:0]  out,
  output logic              out_vld,
  output state_t            dbg_state_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  out_q, out_d;
  logic              vld_q, vld_d;

  logic              wr_req;
  logic [DEPTH-1:0]  we;
  logic [WIDTH-1:0]  rd_data;

  // A load is only honoured in IDLE and only when no clear is requested
  assign wr_req = load && !clr && (state_q == ST_IDLE);

  dmux8way_load u_dmux (
    .load_i (wr_req),
    .addr_i (addr),
    .we_o   (we)
  );

  // 8:1 read mux over the registered words, selected by all 3 addr bits
  assign rd_data = mem_q[addr];

  // Next-state logic for FSM, sweep counter, words and read register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        out_d = rd_data;
        vld_d = 1'b1;
`ifdef RAM8_BANK_BYPASS_EN
        // Same address is both written and read, so any accepted load forwards
        if (wr_req) begin
          out_d = in;
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
          if (we[i]) begin
            mem_d[i] = in;
          end
        end
        if (clr) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end

      default: begin
        // SWEEP: clear one word per cycle, out frozen, read marked invalid
        vld_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_q == ADDR_W'(i)) begin
            mem_d[i] = CLR_VAL;
          end
        end
        // Exit after word 7 instead of letting the counter wrap
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign busy        = (state_q == ST_SWEEP);
  // The read taken on the edge that starts a sweep is masked while busy
  assign out_vld     = vld_q && !busy;
  assign out         = out_q;
  assign dbg_state_o = state_q;

endmodule : ram8_bank
